// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared types for the arcade input front end.
// Scan-code table entry layout, the unused-entry marker and the match helper.
package arcade_input_pkg;

    localparam int SCAN_W = 9;

    typedef struct packed {
        logic       ignore_ext;
        logic       ext;
        logic [7:0] code;
    } key_entry_t;

    localparam key_entry_t KEY_UNUSED = 10'h1FF;

    // An unused slot must never fire, even for an extended 0xFF event.
    function automatic logic key_match(
        input key_entry_t e,
        input logic       ext,
        input logic [7:0] code
    );
        return (e != KEY_UNUSED)
            && (e.code == code)
            && (e.ignore_ext || (e.ext == ext));
    endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// input_pulse_stretch: rising-edge triggered fixed-length pulse generator.
// Ports: clk_sys, reset (async high), level_in, pulse_out (LEN cycles).
module input_pulse_stretch #(
    parameter int LEN = 1200000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt;
    logic          level_q;
    logic          busy;
    logic          rise;

    assign busy = (cnt != '0);
    // Edges during a pulse are dropped so a pulse is never extended.
    assign rise = level_in && !level_q && !busy;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            level_q <= level_in;
            unique case (1'b1)
                busy:    cnt <= cnt - 1'b1;
                rise:    cnt <= CW'(LEN);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pulse_out = busy;

endmodule

// File: rtl/arcade_input_map.sv
// arcade_input_map: PS/2 scan-code table + joystick merge for arcade cores.
// Ports: clk_sys, reset, ps2_key, joystick, map_wr/map_idx/map_code (table
// load), af_mask; outputs btn_out, coin_out, key_hit. Macro INPUT_AUTOFIRE_EN
// adds per-button autofire gated by af_mask.
module arcade_input_map
    import arcade_input_pkg::*;
#(
    parameter int NBTN       = 12,
    parameter int NPLAYERS   = 2,
    parameter int COIN_BIT   = 8,
    parameter int COIN_PULSE = 1200000,
    parameter int AF_DIV     = 1200000,
    localparam int IDX_W     = (NBTN > 1) ? $clog2(NBTN) : 1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [16*NPLAYERS-1:0]  joystick,
    input  logic                    map_wr,
    input  logic [IDX_W-1:0]        map_idx,
    input  logic [SCAN_W:0]         map_code,
    input  logic [NBTN-1:0]         af_mask,
    output logic [NBTN-1:0]         btn_out,
    output logic                    coin_out,
    output logic                    key_hit
);

    key_entry_t      tbl [NBTN];
    logic [NBTN-1:0] key_state;
    logic [NBTN-1:0] hit_vec;
    logic [NBTN-1:0] merged;
    logic [NBTN-1:0] btn_next;
    logic            old_toggle;
    logic            armed;
    logic            key_evt;
    logic            unused_joy;

    // Upper joystick bits beyond NBTN carry nothing for us.
    assign unused_joy = ^joystick;

    // The first cycle after reset only latches the toggle level.
    assign key_evt = armed && (ps2_key[10] != old_toggle);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NBTN; i++)
            hit_vec[i] = key_match(tbl[i], ps2_key[8], ps2_key[7:0]);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_toggle <= 1'b0;
            armed      <= 1'b0;
            key_state  <= '0;
            key_hit    <= 1'b0;
        end else begin
            old_toggle <= ps2_key[10];
            armed      <= 1'b1;
            key_hit    <= key_evt && (|hit_vec);
            for (int i = 0; i < NBTN; i++)
                if (key_evt && hit_vec[i])
                    key_state[i] <= ps2_key[9];
        end
    end

    // Matching reads the registered table, so a same-cycle write is
    // only seen by later events.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBTN; i++)
                tbl[i] <= KEY_UNUSED;
        end else if (map_wr && (int'(map_idx) < NBTN)) begin
            tbl[map_idx] <= map_code;
        end
    end

    always_comb begin
        merged = key_state;
        for (int p = 0; p < NPLAYERS; p++)
            merged = merged | joystick[16*p +: NBTN];
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AF_W = $clog2(AF_DIV + 1);

    logic [AF_W-1:0] af_cnt;
    logic            af_phase;
    logic            af_hold;
    logic            af_wrap;

    assign af_hold = |(merged & af_mask);
    assign af_wrap = (af_cnt == AF_W'(AF_DIV - 1));

    // Idle keeps phase high so the first shot fires on press.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else begin
            unique case (1'b1)
                !af_hold: begin
                    af_cnt   <= '0;
                    af_phase <= 1'b1;
                end
                af_wrap: begin
                    af_cnt   <= '0;
                    af_phase <= ~af_phase;
                end
                default: af_cnt <= af_cnt + 1'b1;
            endcase
        end
    end

    assign btn_next = merged & ~(af_mask & {NBTN{~af_phase}});
`else
    logic unused_af;

    assign unused_af = ^af_mask;
    assign btn_next  = merged;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            btn_out <= '0;
        else
            btn_out <= btn_next;
    end

    input_pulse_stretch #(
        .LEN(COIN_PULSE)
    ) u_coin (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .level_in (merged[COIN_BIT]),
        .pulse_out(coin_out)
    );

endmodule

// File: tb/tb_arcade_input_map.sv
// tb_arcade_input_map: directed bench with a cycle model of the input map.
// Model follows the behavioural rules; compare runs every cycle.
module tb_arcade_input_map;

    localparam int NBTN = 12;
    localparam int NPL  = 2;
    localparam int CBIT = 8;
    localparam int CP   = 10;
    localparam int AFD  = 4;

    logic            clk_sys = 1'b0;
    logic            reset   = 1'b1;
    logic [10:0]     ps2_key = '0;
    logic [31:0]     joystick = '0;
    logic            map_wr  = 1'b0;
    logic [3:0]      map_idx = '0;
    logic [9:0]      map_code = '0;
    logic [NBTN-1:0] af_mask = '0;
    logic [NBTN-1:0] btn_out;
    logic            coin_out;
    logic            key_hit;

    int n_checks = 0;
    int n_fail   = 0;

    arcade_input_map #(
        .NBTN(NBTN),
        .NPLAYERS(NPL),
        .COIN_BIT(CBIT),
        .COIN_PULSE(CP),
        .AF_DIV(AFD)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .joystick(joystick),
        .map_wr  (map_wr),
        .map_idx (map_idx),
        .map_code(map_code),
        .af_mask (af_mask),
        .btn_out (btn_out),
        .coin_out(coin_out),
        .key_hit (key_hit)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0]      m_tbl [NBTN];
    logic [NBTN-1:0] m_key = '0;
    logic [NBTN-1:0] m_merged;
    logic            m_armed = 1'b0;
    logic            m_tog = 1'b0;
    logic            m_ev;
    int              m_nhit;
    int              coin_left = 0;
    logic            coin_prev = 1'b0;
    int              af_held = 0;
    logic            m_phase;
    logic [NBTN-1:0] exp_btn = '0;
    logic            exp_hit = 1'b0;
    logic            exp_coin = 1'b0;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBTN; i++) m_tbl[i] = 10'h1FF;
            m_key = '0; m_armed = 1'b0; m_tog = 1'b0;
            coin_left = 0; coin_prev = 1'b0; af_held = 0;
            exp_btn = '0; exp_hit = 1'b0; exp_coin = 1'b0;
        end else begin
            m_merged = m_key;
            for (int p = 0; p < NPL; p++)
                m_merged = m_merged | joystick[16*p +: NBTN];
            m_ev = m_armed && (ps2_key[10] != m_tog);
            m_armed = 1'b1;
            m_tog = ps2_key[10];
            m_nhit = 0;
            if (m_ev)
                for (int i = 0; i < NBTN; i++)
                    if (m_tbl[i] != 10'h1FF
                        && m_tbl[i][7:0] == ps2_key[7:0]
                        && (m_tbl[i][9] || m_tbl[i][8] == ps2_key[8])) begin
                        m_key[i] = ps2_key[9];
                        m_nhit++;
                    end
            exp_hit = (m_nhit > 0);
            if (map_wr && map_idx < NBTN) m_tbl[map_idx] = map_code;
            if (coin_left > 0) coin_left--;
            else if (m_merged[CBIT] && !coin_prev) coin_left = CP;
            coin_prev = m_merged[CBIT];
            exp_coin = (coin_left > 0);
`ifdef INPUT_AUTOFIRE_EN
            if (|(m_merged & af_mask)) begin
                m_phase = ((af_held / AFD) % 2) == 0;
                af_held++;
            end else begin
                m_phase = 1'b1;
                af_held = 0;
            end
            exp_btn = m_phase ? m_merged : (m_merged & ~af_mask);
`else
            exp_btn = m_merged;
`endif
        end
    end

    always @(posedge clk_sys) begin
        #1;
        if (!reset) begin
            chk("model_btn", 32'(btn_out), 32'(exp_btn));
            chk("model_hit", 32'(key_hit), 32'(exp_hit));
            chk("model_coin", 32'(coin_out), 32'(exp_coin));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_key(input logic pr, input logic ex,
                            input logic [7:0] c);
        ps2_key = {~ps2_key[10], pr, ex, c};
        tick(1);
    endtask

    task automatic write_map(input logic [3:0] i, input logic [9:0] c);
        map_wr = 1'b1; map_idx = i; map_code = c;
        tick(1);
        map_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        tick(3);
        chk("rst_btn", 32'(btn_out), 0);
        chk("rst_coin", 32'(coin_out), 0);
        chk("rst_hit", 32'(key_hit), 0);
        reset = 1'b0;
        tick(2);

        // basic map + press/release
        write_map(4'd5, 10'h229);
        send_key(1'b1, 1'b0, 8'h29);
        chk("hit_pulse", 32'(key_hit), 1);
        chk("btn5_lag", 32'(btn_out[5]), 0);
        tick(1);
        chk("hit_one_cycle", 32'(key_hit), 0);
        chk("btn5_on", 32'(btn_out[5]), 1);
        send_key(1'b0, 1'b0, 8'h29);
        tick(1);
        chk("btn5_off", 32'(btn_out[5]), 0);

        // ignore-extended vs exact extended
        write_map(4'd3, 10'h275);
        write_map(4'd4, 10'h175);
        send_key(1'b1, 1'b1, 8'h75);
        tick(1);
        chk("ext_both", 32'(btn_out[4:3]), 32'h3);
        send_key(1'b0, 1'b1, 8'h75);
        send_key(1'b1, 1'b0, 8'h75);
        tick(1);
        chk("noext_only3", 32'(btn_out[4:3]), 32'h1);
        send_key(1'b0, 1'b0, 8'h75);
        send_key(1'b1, 1'b1, 8'hFF);
        chk("unused_nomatch", 32'(key_hit), 0);
        tick(1);

        // player 1 joystick merge
        joystick[16+7] = 1'b1;
        tick(1);
        chk("joy_p1", 32'(btn_out), 32'h080);
        joystick = '0;
        tick(1);

        // coin stretcher with a re-press inside the pulse
        joystick[CBIT] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (coin_out) cnt++;
            if (i == 3) joystick[CBIT] = 1'b0;
            if (i == 5) joystick[CBIT] = 1'b1;
        end
        chk("coin_len", 32'(cnt), CP);
        joystick = '0;
        tick(2);

        // write coincident with event, then same event again
        map_wr = 1'b1; map_idx = 4'd2; map_code = 10'h01C;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
        tick(1);
        map_wr = 1'b0;
        chk("coinc_nohit", 32'(key_hit), 0);
        send_key(1'b1, 1'b0, 8'h1C);
        chk("late_hit", 32'(key_hit), 1);
        tick(1);
        chk("late_btn2", 32'(btn_out[2]), 1);

        // out-of-range index ignored
        write_map(4'd13, 10'h01D);
        send_key(1'b1, 1'b0, 8'h1D);
        chk("idx_oob", 32'(key_hit), 0);

        // reset mid-pulse / mid-press
        joystick[CBIT] = 1'b1;
        tick(1);
        chk("coin_pre_rst", 32'(coin_out), 1);
        reset = 1'b1;
        #1;
        chk("async_btn", 32'(btn_out), 0);
        chk("async_coin", 32'(coin_out), 0);
        joystick = '0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
        tick(2);
        reset = 1'b0;
        write_map(4'd5, 10'h229);
        tick(2);
        chk("arm_noevent", 32'(btn_out), 0);
        send_key(1'b1, 1'b0, 8'h29);
        tick(1);
        chk("post_arm_btn5", 32'(btn_out[5]), 1);
        send_key(1'b0, 1'b0, 8'h29);
        tick(1);

        // autofire (or plain hold when disabled)
        af_mask = '0;
        af_mask[5] = 1'b1;
        joystick[5] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(1);
`ifdef INPUT_AUTOFIRE_EN
            chk("af_pattern", 32'(btn_out[5]), 32'(((i / 4) % 2) == 0));
`else
            chk("hold_level", 32'(btn_out[5]), 1);
`endif
        end
        joystick = '0;
        af_mask = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arcade_input_map.md
# arcade_input_map

Parametrised control-input front end for arcade cores, between `hps_io` and the game core. Decodes PS/2 key events against a runtime-loadable scan-code table, merges them with the joystick words of every player, and delivers registered button levels to the core. Also produces a fixed-length coin pulse and, optionally, per-button autofire.

## Interface
Parameters:
- `NBTN`, 12: number of mapped buttons, 1..16. Button i also takes joystick bit i.
- `NPLAYERS`, 2: number of joystick words merged, 1..4.
- `COIN_BIT`, 8: index of the button that drives the coin stretcher.
- `COIN_PULSE`, 1200000: coin pulse length in `clk_sys` cycles, ≥1 (50 ms at 24 MHz).
- `AF_DIV`, 1200000: autofire half-period in cycles, ≥1.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ps2_key` in 11: [10] toggle, [9] pressed, [8] extended, [7:0] code.
- `joystick` in 16*NPLAYERS: player p occupies [16p+15:16p].
- `map_wr` in 1: table write strobe.
- `map_idx` in clog2(NBTN): entry written.
- `map_code` in 10: [9] ignore-extended, [8:0] code.
- `af_mask` in NBTN: per-button autofire enable.
- `btn_out` out NBTN: registered button levels.
- `coin_out` out 1: stretched coin pulse.
- `key_hit` out 1: one-cycle pulse when a key event matched ≥1 entry.

Clock is `clk_sys`. Reset is asynchronous and active-high.

## Operation
- Reset values:
  - `btn_out`, `coin_out`, `key_hit` = 0.
  - Key state all 0. Coin counter 0.
  - Every table entry = `KEY_UNUSED` (10'h1FF, never matches).
  - `armed` = 0. Autofire phase = 1.
- Event detect:
  - First cycle after reset: copy `ps2_key[10]` into `old_toggle`, set `armed`, generate no event.
  - After that, `ps2_key[10] != old_toggle` = one event. Update `old_toggle` every cycle.
- Match:
  - Entry e matches when `code[7:0]` equals e[7:0] and either e[9]=1 or `ps2_key[8]` equals e[8].
  - Every matching entry's key-state bit loads `ps2_key[9]`. Several entries may match one key.
  - `key_hit` pulses in the same update cycle.
- Table write:
  - `map_wr` writes `map_code` to entry `map_idx`. `map_idx` ≥ NBTN is ignored.
  - A write does not alter key state.
  - A write coinciding with an event: the match uses the pre-write entry.
- Merge: button i = key_state[i] OR joystick bit i of each player.
- Coin stretcher:
  - A rising edge of merged button `COIN_BIT` while the counter is 0 loads `COIN_PULSE`.
  - `coin_out` = (counter ≠ 0). Counter decrements to 0.
  - Edges while active are ignored. Release does not shorten the pulse.
  - Holding the button past the pulse gives no second pulse until release and re-press.
- Reset mid-pulse or mid-press: all state returns to the reset values immediately.

## Timing
- Joystick change at cycle n: `btn_out` updates at n+1.
- Toggle change at cycle n: key state and `key_hit` update at n+1, `btn_out` at n+2.
- Coin:
  - Merged rising edge registered at cycle n: `coin_out` rises at n+1.
  - `coin_out` stays high exactly `COIN_PULSE` cycles.
- Table write at n is visible to events sampled at n+1.

## Configuration
- `INPUT_AUTOFIRE_EN` defined:
  - Counter counts `AF_DIV` cycles, then toggles the phase.
  - While no `af_mask` button is held, counter = 0 and phase = 1, so the first shot fires immediately.
  - For `af_mask[i]`=1, `btn_out[i]` = merged[i] AND phase.
- `INPUT_AUTOFIRE_EN` undefined:
  - No autofire counter is built. `af_mask` is ignored.
  - `btn_out` = merged levels.

## Structure
- Package `arcade_input_pkg`:
  - `SCAN_W`=9.
  - `KEY_UNUSED`=10'h1FF.
  - Typedef `key_entry_t` (ignore_ext, ext, code).
- Sub-module `input_pulse_stretch` holds the edge detect and down-counter. Its length is a parameter. It is reusable for service and tilt inputs.
- Table, matcher, merge and autofire live in the top module.

## Test plan
- Default params: write entry 5 = 10'h229, then toggle with pressed=1, code 0x029 → `key_hit` one cycle later, `btn_out[5]`=1 two cycles later. Release event → 0.
- Entry 3 = 10'h275 (ignore-ext): events 0x175 and 0x075 both set `btn_out[3]`. Entry 4 = 10'h175 matches only 0x175.
- `reset` released with `ps2_key[10]`=1 → no event, `btn_out`=0. Next toggle → normal event.
- `COIN_PULSE`=10: joystick_0[8] held 30 cycles → `coin_out` high exactly 10 cycles. Re-press while high → no extension.
- `INPUT_AUTOFIRE_EN`, `AF_DIV`=4, `af_mask[5]`=1, joystick_0[5] held → `btn_out[5]` pattern 1111 0000 repeating, starting high.
- Write to entry 2 coincident with a matching event for the new code → no effect that cycle. The same event one cycle later sets `btn_out[2]`.
